// File: rtl/tempsense_sar_ctrl.sv
// Successive-approximation sequencer for the temperature-dependent delay cell.
// Define TEMPSENSE_SAR_AVG_EN to average four back-to-back conversions per start.
module tempsense_sar_ctrl #(
   parameter int unsigned N_VDAC      = 6,
   parameter int unsigned MEAS_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      temp_delay,
   output logic                      tempsens_en,
   output logic [N_VDAC-1:0]         tempsens_dat,
   output logic                      tempsens_measure,
   output logic                      busy,
   output logic                      done,
   output logic [N_VDAC-1:0]         result,
   output logic [$clog2(N_VDAC)-1:0] bit_idx
);

   localparam int unsigned BW = $clog2(N_VDAC);
   localparam int unsigned CW = $clog2(MEAS_CYCLES);
   localparam logic [BW-1:0] BIT_TOP  = BW'(N_VDAC - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEAS_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRECHARGE,
      S_TRANSITION,
      S_MEASURE,
      S_EVALUATE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [N_VDAC-1:0] trial_q, trial_d;
   logic [N_VDAC-1:0] result_q, result_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              td_meta_q, td_s_q;
`ifdef TEMPSENSE_SAR_AVG_EN
   logic [N_VDAC+1:0] acc_q, acc_d;
   logic [1:0]        run_q, run_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         trial_q   <= '0;
         result_q  <= '0;
         bit_q     <= BIT_TOP;
         cnt_q     <= '0;
         td_meta_q <= 1'b0;
         td_s_q    <= 1'b0;
`ifdef TEMPSENSE_SAR_AVG_EN
         acc_q     <= '0;
         run_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         trial_q   <= trial_d;
         result_q  <= result_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         td_meta_q <= temp_delay;
         td_s_q    <= td_meta_q;
`ifdef TEMPSENSE_SAR_AVG_EN
         acc_q     <= acc_d;
         run_q     <= run_d;
`endif
      end
   end

   always_comb begin
      state_d          = state_q;
      trial_d          = trial_q;
      result_d         = result_q;
      bit_d            = bit_q;
      cnt_d            = cnt_q;
`ifdef TEMPSENSE_SAR_AVG_EN
      acc_d            = acc_q;
      run_d            = run_q;
`endif
      tempsens_en      = 1'b0;
      tempsens_dat     = '1;
      tempsens_measure = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d             = S_PRECHARGE;
               bit_d               = BIT_TOP;
               trial_d             = '0;
               trial_d[N_VDAC-1]   = 1'b1;
`ifdef TEMPSENSE_SAR_AVG_EN
               acc_d               = '0;
               run_d               = '0;
`endif
            end
         end
         S_PRECHARGE: begin
            tempsens_en = 1'b1;
            busy        = 1'b1;
            state_d     = S_TRANSITION;
         end
         S_TRANSITION: begin
            tempsens_en      = 1'b1;
            tempsens_dat     = '0;
            tempsens_measure = 1'b1;
            busy             = 1'b1;
            cnt_d            = '0;
            state_d          = S_MEASURE;
         end
         S_MEASURE: begin
            tempsens_en      = 1'b1;
            tempsens_dat     = trial_q;
            tempsens_measure = 1'b1;
            busy             = 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_EVALUATE;
            else                   cnt_d   = cnt_q + CW'(1);
         end
         S_EVALUATE: begin
            tempsens_en      = 1'b1;
            tempsens_dat     = trial_q;
            tempsens_measure = 1'b1;
            busy             = 1'b1;
            if (!td_s_q) trial_d[bit_q] = 1'b0;
            if (bit_q != '0) begin
               bit_d                   = bit_q - BW'(1);
               trial_d[bit_q - BW'(1)] = 1'b1;
               state_d                 = S_PRECHARGE;
            end else begin
`ifdef TEMPSENSE_SAR_AVG_EN
               // Fold the finished code in before reseeding the trial for the next run.
               acc_d = acc_q + {2'b00, trial_d};
               if (run_q == 2'd3) begin
                  result_d = acc_d[N_VDAC+1:2];
                  state_d  = S_DONE;
               end else begin
                  run_d             = run_q + 2'd1;
                  bit_d             = BIT_TOP;
                  trial_d           = '0;
                  trial_d[N_VDAC-1] = 1'b1;
                  state_d           = S_PRECHARGE;
               end
`else
               result_d = trial_d;
               state_d  = S_DONE;
`endif
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign result  = result_q;
   assign bit_idx = bit_q;

endmodule
